regfile_access_arbiter: RTL and testbench

Two-master arbiter and access sequencer for the 32x32 register file.
- Two independent requesters (m0, m1) issue single-word read or write transactions with a req/gnt handshake.
- The block arbitrates between them, drives the register file's ce/write port and read port 1, and returns read data with a valid pulse.
- Sits directly between the pipeline/debug masters and the register file; read port 2 is held idle by this block.

---
 rtl/regfile_access_arbiter_if.sv | 19 +
 rtl/regfile_access_arbiter.sv | 175 +++++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_arbiter_if.sv
// Purpose: request/grant/read-return bundle between one master and the regfile arbiter.
// Latency: n/a (wires only).
// Backpressure: master holds req/we/addr/wdata stable until gnt pulses.
// Signals: req, we, addr, wdata (master -> arbiter); gnt, rvalid, rdata (arbiter -> master).
interface regfile_access_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/regfile_access_arbiter.sv
// Purpose: two-master arbiter/sequencer for the 32x32 register file (write + read port 1; port 2 idle).
// Latency: req seen in IDLE at T -> gnt and rf write at T+1; rvalid/rdata at T+3.
// Backpressure: requests sampled only in IDLE; a losing or mid-transaction request waits, req held.
// Ports: clk, rst_n (async, active low); m0/m1 master bundles (slave side);
//        rf_* register file write port, read port 1 (used) and read port 2 (tied off).
module regfile_access_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int FIXED_PRIO  = 0,
  parameter int ZERO_REG_RO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_access_arbiter_if.slave m0,
  regfile_access_arbiter_if.slave m1,
  output logic                  rf_ce,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_rd_en1,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
  output logic                  rf_rd_en2,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;      // 1: m1 was granted last
  logic                  sel_q, sel_d;        // 1: m1 owns the current transaction
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  rf_ce_q, rf_ce_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  rf_rd_en1_q, rf_rd_en1_d;
  logic [ADDR_WIDTH-1:0] rf_rd_addr1_q, rf_rd_addr1_d;

  logic                  win;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rd_val;

  // Winner selection: fixed priority favours m0; round-robin gives a tie to
  // whoever was not granted last.
  always_comb begin
    win = 1'b0;
    if (FIXED_PRIO != 0)          win = !m0.req;
    else if (m0.req && m1.req)    win = !last_q;
    else                          win = !m0.req;
    req_we    = win ? m1.we    : m0.we;
    req_addr  = win ? m1.addr  : m0.addr;
    req_wdata = win ? m1.wdata : m0.wdata;
    rd_val    = ((ZERO_REG_RO != 0) && (addr_q == '0)) ? '0 : rf_rd_data1;
  end

  // Outputs are registered: each *_d is the value for the state being entered.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    sel_d         = sel_q;
    we_d          = we_q;
    addr_d        = addr_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    rf_ce_d       = 1'b0;
    rf_wr_en_d    = 1'b0;
    rf_wr_addr_d  = '0;
    rf_wr_data_d  = '0;
    rf_rd_en1_d   = 1'b0;
    rf_rd_addr1_d = '0;
    unique case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          state_d = ACCESS;
          sel_d   = win;
          last_d  = win;
          we_d    = req_we;
          addr_d  = req_addr;
          gnt0_d  = !win;
          gnt1_d  = win;
          rf_ce_d = 1'b1;
          if (req_we) begin
            // Writes to r0 are acknowledged but never reach the array.
            rf_wr_en_d   = !((ZERO_REG_RO != 0) && (req_addr == '0));
            rf_wr_addr_d = req_addr;
            rf_wr_data_d = req_wdata;
          end else begin
            rf_rd_en1_d   = 1'b1;
            rf_rd_addr1_d = req_addr;
          end
        end
      end
      ACCESS: state_d = we_q ? IDLE : RESP;
      RESP: begin
        state_d = DONE;
        if (sel_q) begin
          rdata1_d  = rd_val;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = rd_val;
          rvalid0_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      sel_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      rf_ce_q       <= 1'b0;
      rf_wr_en_q    <= 1'b0;
      rf_wr_addr_q  <= '0;
      rf_wr_data_q  <= '0;
      rf_rd_en1_q   <= 1'b0;
      rf_rd_addr1_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      rf_ce_q       <= rf_ce_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_addr_q  <= rf_wr_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      rf_rd_en1_q   <= rf_rd_en1_d;
      rf_rd_addr1_q <= rf_rd_addr1_d;
    end
  end

  assign m0.gnt      = gnt0_q;
  assign m1.gnt      = gnt1_q;
  assign m0.rvalid   = rvalid0_q;
  assign m1.rvalid   = rvalid1_q;
  assign m0.rdata    = rdata0_q;
  assign m1.rdata    = rdata1_q;
  assign rf_ce       = rf_ce_q;
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_addr  = rf_wr_addr_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign rf_rd_en1   = rf_rd_en1_q;
  assign rf_rd_addr1 = rf_rd_addr1_q;
  assign rf_rd_en2   = 1'b0;
  assign rf_rd_addr2 = '0;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: instance 0 round-robin with writable r0,
// instance 1 fixed priority with read-only r0; each backed by a small register file model.
module tb_regfile_access_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [4:0]  addr_s  [2][2];
  logic [31:0] wdata_s [2][2];
  logic        gnt_w   [2][2];
  logic        rvalid_w[2][2];
  logic [31:0] rdata_w [2][2];

  logic        ce_w[2], wen_w[2], ren_w[2], ren2_w[2];
  logic [4:0]  waddr_w[2], raddr_w[2], raddr2_w[2];
  logic [31:0] wdat_w[2], rd1_w[2];
  logic [31:0] mem[2][32];
  logic        rd2_bad = 1'b0;

  regfile_access_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) a_m0 ();
  regfile_access_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) a_m1 ();
  regfile_access_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b_m0 ();
  regfile_access_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b_m1 ();

  assign a_m0.req = req_s[0][0];   assign a_m1.req = req_s[0][1];
  assign b_m0.req = req_s[1][0];   assign b_m1.req = req_s[1][1];
  assign a_m0.we  = we_s[0][0];    assign a_m1.we  = we_s[0][1];
  assign b_m0.we  = we_s[1][0];    assign b_m1.we  = we_s[1][1];
  assign a_m0.addr = addr_s[0][0]; assign a_m1.addr = addr_s[0][1];
  assign b_m0.addr = addr_s[1][0]; assign b_m1.addr = addr_s[1][1];
  assign a_m0.wdata = wdata_s[0][0]; assign a_m1.wdata = wdata_s[0][1];
  assign b_m0.wdata = wdata_s[1][0]; assign b_m1.wdata = wdata_s[1][1];
  assign gnt_w[0][0] = a_m0.gnt;   assign gnt_w[0][1] = a_m1.gnt;
  assign gnt_w[1][0] = b_m0.gnt;   assign gnt_w[1][1] = b_m1.gnt;
  assign rvalid_w[0][0] = a_m0.rvalid; assign rvalid_w[0][1] = a_m1.rvalid;
  assign rvalid_w[1][0] = b_m0.rvalid; assign rvalid_w[1][1] = b_m1.rvalid;
  assign rdata_w[0][0] = a_m0.rdata; assign rdata_w[0][1] = a_m1.rdata;
  assign rdata_w[1][0] = b_m0.rdata; assign rdata_w[1][1] = b_m1.rdata;

  regfile_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(0), .ZERO_REG_RO(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .m0(a_m0), .m1(a_m1),
    .rf_ce(ce_w[0]), .rf_wr_en(wen_w[0]), .rf_wr_addr(waddr_w[0]), .rf_wr_data(wdat_w[0]),
    .rf_rd_en1(ren_w[0]), .rf_rd_addr1(raddr_w[0]), .rf_rd_en2(ren2_w[0]),
    .rf_rd_addr2(raddr2_w[0]), .rf_rd_data1(rd1_w[0]));

  regfile_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(1), .ZERO_REG_RO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .m0(b_m0), .m1(b_m1),
    .rf_ce(ce_w[1]), .rf_wr_en(wen_w[1]), .rf_wr_addr(waddr_w[1]), .rf_wr_data(wdat_w[1]),
    .rf_rd_en1(ren_w[1]), .rf_rd_addr1(raddr_w[1]), .rf_rd_en2(ren2_w[1]),
    .rf_rd_addr2(raddr2_w[1]), .rf_rd_data1(rd1_w[1]));

  // Register file model: synchronous write, registered read on port 1.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ce_w[d] && wen_w[d]) mem[d][waddr_w[d]] <= wdat_w[d];
      if (ce_w[d] && ren_w[d]) rd1_w[d] <= mem[d][raddr_w[d]];
    end
  end

  always @(negedge clk) begin
    if (ren2_w[0] || ren2_w[1] || (raddr2_w[0] != 5'd0) || (raddr2_w[1] != 5'd0))
      rd2_bad <= 1'b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int          d;
    int          m;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[12];

  // One transaction from an idle arbiter: checks gnt latency, the register
  // file port activity in the grant cycle, and for reads the rvalid latency/data.
  task automatic txn(input vec_t v);
    int n;
    int o;
    o = 1 - v.m;
    req_s[v.d][v.m]   = 1'b1;
    we_s[v.d][v.m]    = v.we;
    addr_s[v.d][v.m]  = v.addr;
    wdata_s[v.d][v.m] = v.wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_w[v.d][v.m] && n < 20);
    chk("gnt_lat", n, 1);
    chk("gnt_other", gnt_w[v.d][o], 0);
    chk("rf_ce", ce_w[v.d], 1);
    chk("rf_wr_en", wen_w[v.d], v.we ? v.exp_wen : 1'b0);
    if (v.we && v.exp_wen) begin
      chk("rf_wr_addr", waddr_w[v.d], v.addr);
      chk("rf_wr_data", wdat_w[v.d], v.wdata);
    end
    if (!v.we) begin
      chk("rf_rd_en1", ren_w[v.d], 1);
      chk("rf_rd_addr1", raddr_w[v.d], v.addr);
    end
    req_s[v.d][v.m] = 1'b0;
    if (!v.we) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!rvalid_w[v.d][v.m] && n < 10);
      chk("rvalid_lat", n, 2);
      chk("rdata", rdata_w[v.d][v.m], v.exp_rd);
      chk("rvalid_other", rvalid_w[v.d][o], 0);
    end
    @(negedge clk);
  endtask

  initial begin
    int n0, n1, n, exp_own;
    logic saw_rv;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) begin
        req_s[d][m] = 1'b0; we_s[d][m] = 1'b0; addr_s[d][m] = 5'd0; wdata_s[d][m] = 32'd0;
      end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt0", gnt_w[d][0], 0);
      chk("rst_gnt1", gnt_w[d][1], 0);
      chk("rst_rvalid0", rvalid_w[d][0], 0);
      chk("rst_rdata1", rdata_w[d][1], 0);
      chk("rst_rf_ce", ce_w[d], 0);
      chk("rst_rf_wr_en", wen_w[d], 0);
      chk("rst_rf_rd_en1", ren_w[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    //           d  m  we    addr   wdata          exp_rd         exp_wen
    vecs[0]  = '{0, 0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1};
    vecs[1]  = '{0, 0, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 1, 1'b1, 5'd31, 32'hA5A5A5A5, 32'h0,        1'b1};
    vecs[3]  = '{0, 0, 1'b0, 5'd31, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[4]  = '{0, 1, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[5]  = '{0, 0, 1'b0, 5'd0,  32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{0, 0, 1'b1, 5'd1,  32'h00000011, 32'h0,        1'b1};
    vecs[7]  = '{0, 1, 1'b1, 5'd2,  32'h00000022, 32'h0,        1'b1};
    vecs[8]  = '{1, 0, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[9]  = '{1, 1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0};
    vecs[10] = '{1, 1, 1'b1, 5'd7,  32'h00000077, 32'h0,        1'b1};
    vecs[11] = '{1, 0, 1'b0, 5'd7,  32'h0,        32'h00000077, 1'b0};
    for (int i = 0; i < 12; i++) txn(vecs[i]);

    // Round-robin, both reading continuously: grants alternate starting at m0.
    we_s[0][0] = 1'b0; addr_s[0][0] = 5'd1; req_s[0][0] = 1'b1;
    we_s[0][1] = 1'b0; addr_s[0][1] = 5'd2; req_s[0][1] = 1'b1;
    exp_own = 0; n = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (gnt_w[0][0] && gnt_w[0][1]) chk("rr_both_gnt", 1, 0);
      else if (gnt_w[0][0]) begin chk("rr_order", 0, exp_own); exp_own = 1; n++; end
      else if (gnt_w[0][1]) begin chk("rr_order", 1, exp_own); exp_own = 0; n++; end
      if (rvalid_w[0][0]) chk("rr_rdata_m0", rdata_w[0][0], 32'h11);
      if (rvalid_w[0][1]) chk("rr_rdata_m1", rdata_w[0][1], 32'h22);
    end
    chk("rr_gnt_count", n, 6);
    req_s[0][0] = 1'b0; req_s[0][1] = 1'b0;
    repeat (3) @(negedge clk);

    // Fixed priority: m0 writing continuously starves m1 until it lets go.
    we_s[1][0] = 1'b1; addr_s[1][0] = 5'd9; wdata_s[1][0] = 32'h99; req_s[1][0] = 1'b1;
    we_s[1][1] = 1'b0; addr_s[1][1] = 5'd0; req_s[1][1] = 1'b1;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt_w[1][0]) n0++;
      if (gnt_w[1][1]) n1++;
    end
    chk("fp_m1_starved", n1, 0);
    chk("fp_m0_gnts", n0, 5);
    req_s[1][0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt_w[1][1] && n < 4);
    chk("fp_m1_gnt_within2", (n <= 2) && gnt_w[1][1], 1);
    req_s[1][1] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid_w[1][1] && n < 8);
    chk("fp_m1_rvalid_lat", n, 2);
    chk("fp_r0_reads_zero", rdata_w[1][1], 0);
    repeat (2) @(negedge clk);

    // Reset during RESP of an m1 read aborts it.
    we_s[0][1] = 1'b0; addr_s[0][1] = 5'd2; req_s[0][1] = 1'b1;
    @(negedge clk);
    chk("ab_gnt_m1", gnt_w[0][1], 1);
    req_s[0][1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ab_rst_gnt1", gnt_w[0][1], 0);
    chk("ab_rst_rvalid1", rvalid_w[0][1], 0);
    chk("ab_rst_rdata1", rdata_w[0][1], 0);
    chk("ab_rst_rdata0", rdata_w[0][0], 0);
    chk("ab_rst_rf_ce", ce_w[0], 0);
    chk("ab_rst_rf_rd_en1", ren_w[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_rv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid_w[0][1] || gnt_w[0][1]) saw_rv = 1'b1;
    end
    chk("ab_no_m1_rvalid", saw_rv, 0);
    we_s[0][0] = 1'b0; addr_s[0][0] = 5'd1; req_s[0][0] = 1'b1;
    req_s[0][1] = 1'b1;
    @(negedge clk);
    chk("ab_first_gnt_m0", gnt_w[0][0], 1);
    chk("ab_first_gnt_not_m1", gnt_w[0][1], 0);
    req_s[0][0] = 1'b0; req_s[0][1] = 1'b0;
    repeat (8) @(negedge clk);

    chk("rd_port2_idle", rd2_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
